// File: rtl/result_axis_tx.sv
// Captures one finished N x N result matrix from the systolic array and streams it
// row-major onto an AXI-Stream master, one element per beat, with TLAST on the last element.
module result_axis_tx #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_c_valid,
    input  logic [N*N*DATA_W-1:0] i_c_data,
    output logic                  o_c_ack,
    input  logic                  i_abort,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_frame_cnt
);

    localparam int BEATS = N * N;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N*N*DATA_W-1:0]   shadow_q, shadow_d;
    logic                    ack_q, ack_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    is_last;

    assign is_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        ack_d    = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_c_valid) begin
                    shadow_d = i_c_data;
                    idx_d    = '0;
                    ack_d    = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // Abort wins over a coincident handshake: that beat is never counted.
                if (i_abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (m_axis_tready) begin
                    if (is_last) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            ack_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decode straight from reset-cleared flops so they drop the instant reset asserts.
    always_comb begin
        m_axis_tvalid = (state_q == SEND);
        m_axis_tlast  = m_axis_tvalid & is_last;
        m_axis_tdata  = '0;
        if (m_axis_tvalid) begin
            m_axis_tdata = shadow_q[idx_q*DATA_W +: DATA_W];
        end
    end

    assign o_c_ack     = ack_q;
    assign o_busy      = (state_q == SEND);
    assign o_frame_cnt = cnt_q;

endmodule
